// File: rtl/shift_register_bank.sv
// Word-wide shift chain of DEPTH stages with per-stage valid flags and a registered occupancy count.
// Define SHIFT_REGISTER_BANK_REVERSE_EN to build the BACK and ROT modes; without it, those modes hold.
module shift_register_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qtail,
  output logic [WIDTH-1:0] Qhead,
  output logic             ValidHead,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Empty
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_BACK = 2'b10,
    MODE_ROT  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mode_e            mode;

  assign mode = mode_e'(Mode);

  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (Clear) begin
      v_d   = '0;
      cnt_d = '0;
    end else if (En) begin
      case (mode)
        MODE_FWD: begin
          for (int unsigned i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
          s_d[0] = D;
          v_d    = {v_q[DEPTH-2:0], 1'b1};
          // A new valid word only raises occupancy if it did not push a valid one out.
          if (!v_q[DEPTH-1]) cnt_d = cnt_q + CW'(1);
        end
`ifdef SHIFT_REGISTER_BANK_REVERSE_EN
        MODE_BACK: begin
          for (int unsigned i = 0; i < DEPTH - 1; i++) s_d[i] = s_q[i+1];
          s_d[DEPTH-1] = D;
          v_d          = {1'b1, v_q[DEPTH-1:1]};
          if (!v_q[0]) cnt_d = cnt_q + CW'(1);
        end
        MODE_ROT: begin
          for (int unsigned i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
          s_d[0] = s_q[DEPTH-1];
          v_d    = {v_q[DEPTH-2:0], v_q[DEPTH-1]};
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) s_q[i] <= '0;
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign Qtail     = s_q[0];
  assign Qhead     = s_q[DEPTH-1];
  assign ValidHead = v_q[DEPTH-1];
  assign Count     = cnt_q;
  assign Full      = (cnt_q == CW'(DEPTH));
  assign Empty     = (cnt_q == '0);

endmodule

// File: tb/tb_shift_register_bank.sv
// Scoreboard bench for shift_register_bank: an array model predicts outputs per edge, queued and compared after the edge.
module tb_shift_register_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Reset, Clear, En;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Qtail, Qhead;
  logic             ValidHead, Full, Empty;
  logic [CW-1:0]    Count;

  shift_register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .Mode(Mode), .D(D),
    .Qtail(Qtail), .Qhead(Qhead), .ValidHead(ValidHead), .Count(Count),
    .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [WIDTH-1:0] qtail;
    logic [WIDTH-1:0] qhead;
    logic             vh;
    int               count;
    logic             full;
    logic             empty;
  } exp_t;

  exp_t exp_q[$];

  logic [WIDTH-1:0] m_s [DEPTH];
  logic             m_v [DEPTH];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    int   pc = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) pc++;
    e.qtail = m_s[0];
    e.qhead = m_s[DEPTH-1];
    e.vh    = m_v[DEPTH-1];
    e.count = pc;
    e.full  = (pc == DEPTH);
    e.empty = (pc == 0);
    return e;
  endfunction

  task automatic model_update(input logic rst, input logic clr, input logic en,
                              input logic [1:0] md, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] ts [DEPTH];
    logic             tv [DEPTH];
    ts = m_s;
    tv = m_v;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_s[i] = '0; m_v[i] = 1'b0; end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    end else if (en) begin
      if (md == 2'b01) begin
        m_s[0] = d; m_v[0] = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin m_s[i] = ts[i-1]; m_v[i] = tv[i-1]; end
      end
`ifdef SHIFT_REGISTER_BANK_REVERSE_EN
      else if (md == 2'b10) begin
        m_s[DEPTH-1] = d; m_v[DEPTH-1] = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin m_s[i] = ts[i+1]; m_v[i] = tv[i+1]; end
      end else if (md == 2'b11) begin
        m_s[0] = ts[DEPTH-1]; m_v[0] = tv[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin m_s[i] = ts[i-1]; m_v[i] = tv[i-1]; end
      end
`endif
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic rst, input logic clr, input logic en,
                      input logic [1:0] md, input logic [WIDTH-1:0] d);
    exp_t e;
    Reset = rst; Clear = clr; En = en; Mode = md; D = d;
    model_update(rst, clr, en, md, d);
    exp_q.push_back(model_outputs());
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("Qtail", 32'(Qtail), 32'(e.qtail));
      check("Qhead", 32'(Qhead), 32'(e.qhead));
      check("ValidHead", 32'(ValidHead), 32'(e.vh));
      check("Count", 32'(Count), 32'(e.count));
      check("Full", 32'(Full), 32'(e.full));
      check("Empty", 32'(Empty), 32'(e.empty));
    end
  endtask

  task automatic fwd(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b0, 1'b1, 2'b01, d);
  endtask

  initial begin
    Reset = 1'b1; Clear = 1'b0; En = 1'b0; Mode = 2'b00; D = '0;
    for (int i = 0; i < DEPTH; i++) begin m_s[i] = 'x; m_v[i] = 1'bx; end

    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    check("reset_empty", 32'(Empty), 32'd1);
    check("reset_count", 32'(Count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'b01, 8'hFF);

    fwd(8'h11); fwd(8'h22); fwd(8'h33); fwd(8'h44);
    check("fill_head", 32'(Qhead), 32'h11);
    check("fill_tail", 32'(Qtail), 32'h44);
    check("fill_full", 32'(Full), 32'd1);
    fwd(8'h55);
    check("over_head", 32'(Qhead), 32'h22);
    check("over_count", 32'(Count), 32'd4);

    step(1'b0, 1'b1, 1'b1, 2'b01, 8'hAA);
    check("clr_tail", 32'(Qtail), 32'h55);
    check("clr_vh", 32'(ValidHead), 32'd0);

    // Rotate sequence from a full 11/22/33/44 chain.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    fwd(8'h11); fwd(8'h22); fwd(8'h33); fwd(8'h44);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'b11, 8'hEE);
    check("rot_restore_head", 32'(Qhead), 32'h11);
    check("rot_restore_tail", 32'(Qtail), 32'h44);

    // Reverse sequence from empty.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'b10, 8'h5A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'b10, 8'(8'h60 + i));

    // Reset in the middle of a fill.
    step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    fwd(8'hA1); fwd(8'hA2);
    step(1'b1, 1'b0, 1'b1, 2'b01, 8'hA3);
    check("midreset_count", 32'(Count), 32'd0);
    fwd(8'hA4);

    // Mixed random traffic with occasional clear and reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
